// File: rtl/engine_sched.sv
// Command sequencer for the conv/pool engine: accepts one csb command, feeds operands, waits for the engine result.
// Optional DRAIN watchdog enabled by defining ENGINE_SCHED_TIMEOUT_EN (limit set by TIMEOUT).
module engine_sched #(
    parameter int OP_W    = 3,
    parameter int NUM_W   = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [NUM_W-1:0] cmd_num,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    output logic [OP_W-1:0]  op_type,
    output logic [NUM_W-1:0] op_num,
    output logic             conv_ready,
    output logic             maxpool_ready,
    output logic             avepool_ready,
    input  logic             conv_valid,
    input  logic             maxpool_valid,
    input  logic             avepool_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       fsm_state
);
    // cmd_valid/cmd_ready: a command transfers on a rising edge where both are 1.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [OP_W-1:0] OP_CONV1 = OP_W'(1);
    localparam logic [OP_W-1:0] OP_CONV3 = OP_W'(2);
    localparam logic [OP_W-1:0] OP_CONVP = OP_W'(3);
    localparam logic [OP_W-1:0] OP_MPOOL = OP_W'(4);
    localparam logic [OP_W-1:0] OP_APOOL = OP_W'(5);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("engine_sched: TIMEOUT must be at least 1");
    end

    function automatic logic is_conv(input logic [OP_W-1:0] op);
        return (op == OP_CONV1) || (op == OP_CONV3) || (op == OP_CONVP);
    endfunction

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return is_conv(op) || (op == OP_MPOOL) || (op == OP_APOOL);
    endfunction

    state_t           state;
    logic [NUM_W-1:0] cnt;
    logic             err_q;
    logic             engine_valid;

    assign fsm_state = state;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign err       = done & err_q;
    assign fifo_rd   = (state == FEED) && !fifo_empty;

    // Only the valid line belonging to the current opcode can finish DRAIN.
    assign engine_valid = (is_conv(op_type) && conv_valid)
                        || ((op_type == OP_MPOOL) && maxpool_valid)
                        || ((op_type == OP_APOOL) && avepool_valid);

`ifdef ENGINE_SCHED_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WD_W-1:0] wd;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            op_type       <= '0;
            op_num        <= '0;
            err_q         <= 1'b0;
            conv_ready    <= 1'b0;
            maxpool_ready <= 1'b0;
            avepool_ready <= 1'b0;
`ifdef ENGINE_SCHED_TIMEOUT_EN
            wd            <= '0;
`endif
        end else begin
            // Strobes trail the read by one cycle so they line up with FIFO data.
            conv_ready    <= fifo_rd && is_conv(op_type);
            maxpool_ready <= fifo_rd && (op_type == OP_MPOOL);
            avepool_ready <= fifo_rd && (op_type == OP_APOOL);

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_type <= cmd_op;
                        op_num  <= cmd_num;
                        cnt     <= '0;
                        if (!is_legal(cmd_op)) begin
                            err_q <= 1'b1;
                            state <= DONE;
                        end else if (cmd_num == '0) begin
                            err_q <= 1'b0;
                            state <= DONE;
                        end else begin
                            err_q <= 1'b0;
                            state <= FEED;
                        end
                    end
                end
                FEED: begin
                    if (fifo_rd) begin
                        cnt <= cnt + NUM_W'(1);
                        if (cnt == op_num - NUM_W'(1)) begin
                            state <= DRAIN;
`ifdef ENGINE_SCHED_TIMEOUT_EN
                            wd    <= '0;
`endif
                        end
                    end
                end
                DRAIN: begin
                    if (engine_valid) begin
                        err_q <= 1'b0;
                        state <= DONE;
                    end
`ifdef ENGINE_SCHED_TIMEOUT_EN
                    else if (wd == WD_W'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/engine_sched.md
# engine_sched

Command sequencer for the convolution/pooling engine. Accepts one operation at a time from the control/status block (csb), pulls operands from the DMA-side operand FIFO, and drives the engine's `conv_ready`/`maxpool_ready`/`avepool_ready` strobes with `op_type`/`op_num`. It then waits for the matching engine valid and reports completion to csb. It sits between csb, the operand FIFOs and `engine`, and is the only master of the engine's control inputs.

## Interface
- `OP_W`, 3, opcode width
- `NUM_W`, 32, operand count width
- `TIMEOUT`, 4096, drain watchdog limit in cycles (used only with `ENGINE_SCHED_TIMEOUT_EN`)

Ports:
- `clk`  in  1  single clock domain; all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `cmd_valid`  in  1  csb presents a command
- `cmd_ready`  out  1  scheduler can accept a command
- `cmd_op`  in  OP_W  opcode: 1=CONV1, 2=CONV3, 3=CONVP, 4=MPOOL, 5=APOOL
- `cmd_num`  in  NUM_W  operand count for the command
- `fifo_empty`  in  1  operand FIFO empty
- `fifo_rd`  out  1  operand FIFO read strobe; FIFO read latency is 1 cycle
- `op_type`  out  OP_W  opcode forwarded to `engine`
- `op_num`  out  NUM_W  count forwarded to `engine`
- `conv_ready`, `maxpool_ready`, `avepool_ready`  out  1 each  per-operand engine strobes
- `conv_valid`, `maxpool_valid`, `avepool_valid`  in  1 each  engine result valid
- `busy`  out  1  an operation is in flight
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  status qualifying `done`; valid only while `done`=1

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- **IDLE:** `cmd_ready`=1, `busy`=0. On `cmd_valid`, latch `cmd_op` into `op_type` and `cmd_num` into `op_num`, then branch:
  - illegal op (0, 6, 7): go to DONE with `err_q`=1; no FIFO reads, no engine strobes.
  - `cmd_num`==0: go to DONE with `err_q`=0; no engine activity.
  - otherwise: clear operand counter `cnt`, go to FEED.
- **FEED:** `fifo_rd` = !`fifo_empty`, combinational. Each read increments `cnt`. The read with `cnt`==`op_num`-1 moves the state to DRAIN. While the FIFO is empty, FEED stalls indefinitely with no strobes.
- **Engine strobes:** registered copy of `fifo_rd`, delayed one cycle to align with FIFO data, and routed by opcode:
  - CONV1/CONV3/CONVP → `conv_ready`
  - MPOOL → `maxpool_ready`
  - APOOL → `avepool_ready`
  - The other two strobes stay 0.
- **DRAIN:** wait for the valid matching the opcode (`conv_valid` for all CONV ops). On that valid, go to DONE with `err_q`=0. Valids on non-matching lines are ignored. A valid arriving during FEED is ignored; only DRAIN samples it.
- **DONE:** `done`=1 and `err`=`err_q` for exactly one cycle, then IDLE. `cmd_ready`=0 in DONE, so back-to-back commands have at least one IDLE cycle between them.
- `op_type`/`op_num` hold their values from acceptance until the next acceptance.
- `cnt` is `NUM_W` wide. `op_num`=2^32-1 is legal; there is no wrap before the terminal compare.

## Timing
- Reset (`rst_n`=0 at a clock edge):
  - state goes to IDLE.
  - `cnt`, `op_type`, `op_num`, `err_q` and all strobes go to 0.
  - `done`=0, `busy`=0, `err`=0, `fifo_rd`=0.
  - Reset mid-operation abandons the operation: no `done` pulse, and the strobe pipeline is flushed.
- Command accepted at edge T: FEED from T+1. The first `fifo_rd` can occur in cycle T+1, and its engine strobe in cycle T+2.
- With a never-empty FIFO, N operands take N FEED cycles. The last strobe is in the first DRAIN cycle.
- Minimum latency from acceptance to `done`: N+2 cycles (engine valid coincident with the first DRAIN cycle).
- The illegal and zero-count paths pulse `done` in cycle T+1.
- `busy`=1 in FEED, DRAIN and DONE.

## Configuration
- `ENGINE_SCHED_TIMEOUT_EN` defined:
  - a watchdog counts DRAIN cycles.
  - if it reaches `TIMEOUT` without the matching valid, the state goes to DONE with `err`=1.
  - the watchdog clears on entry to DRAIN.
- `ENGINE_SCHED_TIMEOUT_EN` undefined: no watchdog logic, and DRAIN waits forever.

## Test plan
- **CONV3, N=9, FIFO never empty:**
  - exactly 9 `fifo_rd` pulses, then 9 `conv_ready` pulses each one cycle later.
  - `maxpool_ready`/`avepool_ready` stay 0.
  - `conv_valid` 3 cycles into DRAIN → `done`=1, `err`=0 once.
- **MPOOL, N=4, `fifo_empty` toggling every other cycle:**
  - reads occur only when the FIFO is non-empty, for 4 reads total.
  - `maxpool_ready` tracks the reads with 1-cycle delay.
  - a stray `conv_valid` in DRAIN is ignored; `maxpool_valid` completes the operation.
- **Illegal op 7, and op 1 with N=0:**
  - both give `done` in cycle T+1, with `err`=1 and `err`=0 respectively.
  - no `fifo_rd` and no strobes in either case.
- **Reset mid-FEED after 5 of 16 operands of CONVP:**
  - all outputs are 0 the next cycle and the state is IDLE.
  - a new APOOL N=1 command then completes normally.
- **`cmd_valid` held high continuously across two CONV1 N=2 commands:**
  - the second is accepted only in the IDLE cycle after `done`.
  - `op_num` stays stable throughout each operation.
- **With `ENGINE_SCHED_TIMEOUT_EN` and `TIMEOUT`=16, no engine valid:**
  - `done`=1, `err`=1 exactly 16 cycles after DRAIN entry.
  - without the macro, `busy` stays 1 indefinitely.
